// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that shares one SPI_driver among NUM_REQ command sources.
// It sequences each transfer through load, launch, fixed-length shift, capture and an idle gap.
module spi_cmd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int REG_WIDTH  = 8,
    parameter int MSG_LEN    = 2,
    parameter int GAP_CYCLES = 2,
    localparam int DATA_W    = REG_WIDTH * (MSG_LEN - 1)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy,
    output logic                          drv_new_command,
    output logic [REG_WIDTH-1:0]          drv_register_addr,
    output logic [DATA_W-1:0]             drv_write_data,
    input  logic [DATA_W-1:0]             drv_data_read_from_reg,
    output logic [2:0]                    state_dbg
);

    localparam int XFER_CYCLES = REG_WIDTH * MSG_LEN + 2;
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX     = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LAUNCH  = 3'd2,
        S_XFER    = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [IDX_W-1:0]       ptr, ptr_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic                   newcmd_q, newcmd_d;
    logic [REG_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;

    logic                   arb_found;
    logic [NUM_REQ-1:0]     arb_onehot;
    logic [REG_WIDTH-1:0]   arb_addr;
    logic [DATA_W-1:0]      arb_wdata;
    logic [IDX_W-1:0]       ptr_after_owner;

    // First pass covers requesters at or above the pointer, second pass wraps to the bottom.
    always_comb begin
        arb_found  = 1'b0;
        arb_onehot = '0;
        arb_addr   = '0;
        arb_wdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req[i] && (i >= int'(ptr))) begin
                arb_found     = 1'b1;
                arb_onehot    = '0;
                arb_onehot[i] = 1'b1;
                arb_addr      = req_addr[i*REG_WIDTH +: REG_WIDTH];
                arb_wdata     = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req[i]) begin
                arb_found     = 1'b1;
                arb_onehot    = '0;
                arb_onehot[i] = 1'b1;
                arb_addr      = req_addr[i*REG_WIDTH +: REG_WIDTH];
                arb_wdata     = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves to the requester just above the current owner.
    always_comb begin
        ptr_after_owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                ptr_after_owner = (i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ptr_d    = ptr;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        newcmd_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state)
            S_IDLE: begin
                if (arb_found) begin
                    state_d = S_LOAD;
                    gnt_d   = arb_onehot;
                    addr_d  = arb_addr;
                    wdata_d = arb_wdata;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d  = S_LAUNCH;
                newcmd_d = 1'b1;
            end
            S_LAUNCH: begin
                state_d = S_XFER;
                cnt_d   = '0;
            end
            S_XFER: begin
                if (cnt == CNT_W'(XFER_CYCLES - 1)) begin
                    state_d = S_CAPTURE;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_GAP;
                rdata_d = drv_data_read_from_reg;
                ptr_d   = ptr_after_owner;
                gnt_d   = '0;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            newcmd_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            ptr      <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            newcmd_q <= newcmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign gnt               = gnt_q;
    assign done              = done_q;
    assign rdata             = rdata_q;
    assign busy              = busy_q;
    assign drv_new_command   = newcmd_q;
    assign drv_register_addr = addr_q;
    assign drv_write_data    = wdata_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter: completions are checked against an expected queue
// holding owner, completion cycle and captured read data.
module tb_spi_cmd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int REG_W   = 8;
    localparam int DATA_W  = 8;
    localparam int QW      = 16 + NUM_REQ + DATA_W;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*REG_W-1:0]    req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          done;
    logic [DATA_W-1:0]           rdata;
    logic                        busy;
    logic                        drv_new_command;
    logic [REG_W-1:0]            drv_register_addr;
    logic [DATA_W-1:0]           drv_write_data;
    logic [DATA_W-1:0]           drv_data_read_from_reg;
    logic [2:0]                  state_dbg;

    spi_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .REG_WIDTH(REG_W), .MSG_LEN(2), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .drv_new_command(drv_new_command), .drv_register_addr(drv_register_addr),
        .drv_write_data(drv_write_data), .drv_data_read_from_reg(drv_data_read_from_reg),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [QW-1:0] exp_q[$];
    int unsigned base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic start_txn();
        base = cyc;
    endtask

    task automatic goto(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic expect_done(input int k, input logic [NUM_REQ-1:0] d, input logic [DATA_W-1:0] r);
        logic [15:0] c;
        c = 16'(base + k);
        exp_q.push_back({c, d, r});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(gnt), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_cmd"},   32'(drv_new_command), 32'd0);
        check({tag, "_addr"},  32'(drv_register_addr), 32'd0);
        check({tag, "_wdata"}, 32'(drv_write_data), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // scoreboard: pops one entry per done pulse, checks rdata the following cycle
    logic              rd_pend = 1'b0;
    logic [DATA_W-1:0] rd_exp = '0;
    logic [DATA_W-1:0] model_rdata = '0;
    always @(negedge clk) begin
        logic [QW-1:0] e;
        if (!rstn) begin
            rd_pend     = 1'b0;
            model_rdata = '0;
        end else begin
            if (rd_pend) begin
                check("rdata_capture", 32'(rdata), 32'(rd_exp));
                model_rdata = rd_exp;
                rd_pend     = 1'b0;
            end
            if (done !== '0) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", 32'(done), 32'(e[DATA_W +: NUM_REQ]));
                    check("done_cycle", 32'(16'(cyc)), 32'(e[QW-1 -: 16]));
                    check("rdata_hold", 32'(rdata), 32'(model_rdata));
                    rd_pend = 1'b1;
                    rd_exp  = e[DATA_W-1:0];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        req_addr = '0;
        req_wdata = '0;
        drv_data_read_from_reg = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // single write from requester 0
        start_txn();
        req_addr[7:0] = 8'h12; req_wdata[7:0] = 8'hA5; drv_data_read_from_reg = 8'hFF;
        req = 2'b01;
        expect_done(21, 2'b01, 8'h3C);
        goto(1);
        check("s1_gnt", 32'(gnt), 32'h1);
        check("s1_busy", 32'(busy), 32'h1);
        check("s1_cmd_load", 32'(drv_new_command), 32'h0);
        check("s1_addr", 32'(drv_register_addr), 32'h12);
        check("s1_wdata", 32'(drv_write_data), 32'hA5);
        goto(2);
        check("s1_cmd_launch", 32'(drv_new_command), 32'h1);
        goto(3);
        check("s1_cmd_xfer", 32'(drv_new_command), 32'h0);
        check("s1_state_xfer", 32'(state_dbg), 32'h3);
        goto(20);
        drv_data_read_from_reg = 8'h3C;
        check("s1_addr_held", 32'(drv_register_addr), 32'h12);
        goto(21);
        req = 2'b00;
        goto(22);
        check("s1_gnt_gap", 32'(gnt), 32'h0);
        check("s1_busy_gap", 32'(busy), 32'h1);
        goto(24);
        check("s1_busy_idle", 32'(busy), 32'h0);

        // read capture, previous rdata held through the transfer
        start_txn();
        req_addr[7:0] = 8'h34; req_wdata[7:0] = 8'h00; drv_data_read_from_reg = 8'hFF;
        req = 2'b01;
        expect_done(21, 2'b01, 8'h5A);
        goto(10);
        check("s2_rdata_hold", 32'(rdata), 32'h3C);
        goto(20);
        drv_data_read_from_reg = 8'h5A;
        goto(21);
        req = 2'b00;
        goto(22);
        check("s2_rdata", 32'(rdata), 32'h5A);
        goto(24);

        // contention from reset: 0, then 1, then 0 again
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start_txn();
        req_addr = {8'h43, 8'h21}; req_wdata = {8'h22, 8'h11}; drv_data_read_from_reg = 8'h77;
        req = 2'b11;
        expect_done(21, 2'b01, 8'h77);
        expect_done(45, 2'b10, 8'h88);
        expect_done(69, 2'b01, 8'h99);
        goto(1);
        check("s3_gnt0", 32'(gnt), 32'h1);
        check("s3_addr0", 32'(drv_register_addr), 32'h21);
        goto(22);
        drv_data_read_from_reg = 8'h88;
        goto(24);
        check("s3_idle_before_gnt1", 32'(gnt), 32'h0);
        goto(25);
        check("s3_gnt1", 32'(gnt), 32'h2);
        check("s3_addr1", 32'(drv_register_addr), 32'h43);
        check("s3_wdata1", 32'(drv_write_data), 32'h22);
        goto(45);
        req[1] = 1'b0;
        goto(46);
        drv_data_read_from_reg = 8'h99;
        goto(49);
        check("s3_gnt0_again", 32'(gnt), 32'h1);
        check("s3_addr0_again", 32'(drv_register_addr), 32'h21);
        goto(69);
        req = 2'b00;
        goto(72);
        check("s3_busy_idle", 32'(busy), 32'h0);
        goto(74);
        check("s3_no_regrant", 32'(gnt), 32'h0);

        // request arriving while busy
        start_txn();
        req_addr = {8'h66, 8'h55}; req_wdata = {8'hB2, 8'hB1}; drv_data_read_from_reg = 8'hC1;
        req = 2'b01;
        expect_done(21, 2'b01, 8'hC1);
        expect_done(45, 2'b10, 8'hC2);
        goto(4);
        req[1] = 1'b1;
        goto(5);
        check("s4_gnt_kept", 32'(gnt), 32'h1);
        goto(10);
        check("s4_addr_mid", 32'(drv_register_addr), 32'h55);
        check("s4_wdata_mid", 32'(drv_write_data), 32'hB1);
        goto(20);
        check("s4_addr_late", 32'(drv_register_addr), 32'h55);
        goto(21);
        req[0] = 1'b0;
        goto(22);
        drv_data_read_from_reg = 8'hC2;
        goto(24);
        check("s4_addr_idle", 32'(drv_register_addr), 32'h55);
        check("s4_gnt_idle", 32'(gnt), 32'h0);
        goto(25);
        check("s4_gnt1", 32'(gnt), 32'h2);
        check("s4_addr1", 32'(drv_register_addr), 32'h66);
        check("s4_wdata1", 32'(drv_write_data), 32'hB2);
        goto(45);
        req = 2'b00;
        goto(48);
        check("s4_busy_idle", 32'(busy), 32'h0);

        // reset in the middle of the shift
        start_txn();
        drv_data_read_from_reg = 8'hAA;
        req = 2'b01;
        goto(10);
        rstn = 1'b0;
        req = 2'b00;
        #1;
        check_reset_outputs("abort");
        goto(12);
        rstn = 1'b1;
        start_txn();
        drv_data_read_from_reg = 8'hD7;
        req = 2'b10;
        expect_done(21, 2'b10, 8'hD7);
        goto(1);
        check("s5_gnt1", 32'(gnt), 32'h2);
        check("s5_addr1", 32'(drv_register_addr), 32'h66);
        goto(21);
        req = 2'b00;
        goto(24);
        check("s5_busy_idle", 32'(busy), 32'h0);

        // early drop of req still completes, no re-grant
        start_txn();
        drv_data_read_from_reg = 8'hE5;
        req = 2'b01;
        expect_done(21, 2'b01, 8'hE5);
        goto(6);
        req = 2'b00;
        goto(20);
        check("s6_gnt_held", 32'(gnt), 32'h1);
        goto(25);
        check("s6_no_regrant", 32'(gnt), 32'h0);
        check("s6_busy_idle", 32'(busy), 32'h0);
        goto(27);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
